// File: rtl/d_kes_dc_sum_tree_pkg.sv
// Shared constants and elaboration-time helpers for the KES discrepancy
// summation tree.
//   D_KES_GF_ORDER : symbol width of GF(2^12) elements
//   D_KES_DC_GROUP : default stage-1 fan-in of the XOR tree
package d_kes_dc_sum_tree_pkg;

   localparam int D_KES_GF_ORDER = 12;
   localparam int D_KES_DC_GROUP = 4;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Member count of stage-1 group j; the last group may be short.
   function automatic int group_size(input int num_pe, input int group, input int j);
      int rem;
      rem = num_pe - j * group;
      return (rem < group) ? rem : group;
   endfunction

endpackage

// File: rtl/d_kes_dc_sum_tree_xor_reduce.sv
// Combinational N-input GF(2^12) adder (bitwise XOR of N symbols).
//   in_i  : N concatenated W-bit symbols, symbol k at [W*k +: W]
//   sum_o : XOR of all N symbols
module d_kes_dc_sum_tree_xor_reduce
   import d_kes_dc_sum_tree_pkg::*;
#(
   parameter int N = 2,
   parameter int W = D_KES_GF_ORDER
) (
   input  logic [N*W-1:0] in_i,
   output logic [W-1:0]   sum_o
);

   always_comb begin
      sum_o = '0;
      for (int k = 0; k < N; k++) begin
         sum_o = sum_o ^ in_i[k*W +: W];
      end
   end

endmodule

// File: rtl/d_kes_dc_sum_tree.sv
// Two-stage registered GF(2^12) summation of the DC PE products, producing
// the discrepancy delta(2i+1) per iBM iteration plus iteration bookkeeping.
//   i_clk, i_RESET_KES_n : clock, async active-low reset
//   i_stop_dec           : synchronous abort, flushes the pipe and counter
//   i_EXECUTE_PE_DC      : PE execute pulse; products follow one cycle later
//   i_coef_2ip1          : NUM_PE concatenated 12-bit products
//   o_delta_2ip1/_valid  : registered discrepancy and its one-cycle strobe
//   o_delta_zero         : discrepancy is zero (qualified by valid)
//   o_iter_cnt           : index of the presented discrepancy
//   o_dc_done            : strobe with the last discrepancy of a codeword
//
// state | meaning
// IDLE  | no bit of v_q set, nothing in flight
// BUSY  | at least one execute travelling through v_q
// The pipeline never stalls, so the state is implicit in v_q.
module d_kes_dc_sum_tree
   import d_kes_dc_sum_tree_pkg::*;
#(
   parameter int NUM_PE   = 15,
   parameter int NUM_ITER = 14,
   parameter int GROUP    = D_KES_DC_GROUP
) (
   input  logic                             i_clk,
   input  logic                             i_RESET_KES_n,
   input  logic                             i_stop_dec,
   input  logic                             i_EXECUTE_PE_DC,
   input  logic [NUM_PE*D_KES_GF_ORDER-1:0] i_coef_2ip1,
   output logic [D_KES_GF_ORDER-1:0]        o_delta_2ip1,
   output logic                             o_delta_valid,
   output logic                             o_delta_zero,
   output logic [7:0]                       o_iter_cnt,
   output logic                             o_dc_done
);

   localparam int W     = D_KES_GF_ORDER;
   localparam int NPART = ceil_div(NUM_PE, GROUP);
   localparam logic [7:0] LAST_ITER = 8'(NUM_ITER - 1);

   logic [2:0]         v_q;
   logic [NPART*W-1:0] part_d, part_q;
   logic [W-1:0]       delta_d, delta_q;
   logic               zero_q;
   logic [7:0]         iter_q;

   for (genvar j = 0; j < NPART; j++) begin : g_stage1
      localparam int GSZ = group_size(NUM_PE, GROUP, j);
      d_kes_dc_sum_tree_xor_reduce #(.N(GSZ), .W(W)) u_grp (
         .in_i  (i_coef_2ip1[j*GROUP*W +: GSZ*W]),
         .sum_o (part_d[j*W +: W])
      );
   end

   d_kes_dc_sum_tree_xor_reduce #(.N(NPART), .W(W)) u_stage2 (
      .in_i  (part_q),
      .sum_o (delta_d)
   );

   always_ff @(posedge i_clk or negedge i_RESET_KES_n) begin
      if (!i_RESET_KES_n) begin
         v_q     <= '0;
         part_q  <= '0;
         delta_q <= '0;
         zero_q  <= 1'b0;
         iter_q  <= '0;
      end else if (i_stop_dec) begin
         // Abort wins over a coincident execute; in-flight deltas vanish.
         v_q     <= '0;
         part_q  <= '0;
         delta_q <= '0;
         zero_q  <= 1'b0;
         iter_q  <= '0;
      end else begin
         v_q <= {v_q[1:0], i_EXECUTE_PE_DC};
         if (v_q[0]) begin
            part_q <= part_d;
         end
         if (v_q[1]) begin
            delta_q <= delta_d;
            zero_q  <= (delta_d == '0);
         end
         if (v_q[2]) begin
            iter_q <= (iter_q == LAST_ITER) ? 8'd0 : iter_q + 8'd1;
         end
      end
   end

   assign o_delta_2ip1  = delta_q;
   assign o_delta_zero  = zero_q;
   assign o_delta_valid = v_q[2];
   assign o_iter_cnt    = iter_q;
   assign o_dc_done     = v_q[2] & (iter_q == LAST_ITER);

endmodule

// File: tb/tb_d_kes_dc_sum_tree.sv
module tb_d_kes_dc_sum_tree;

   localparam int NPE = 15;
   localparam int NIT = 14;
   localparam int W   = 12;

   typedef logic [NPE*W-1:0] coef_t;

   typedef struct {
      logic [W-1:0] d;
      logic         z;
      logic [7:0]   it;
      logic         dn;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         stop = 1'b0;
   logic         exec = 1'b0;
   coef_t        coef = '0;
   logic [W-1:0] o_delta;
   logic         o_valid, o_zero, o_done;
   logic [7:0]   o_iter;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   exp_iter = 0;

   d_kes_dc_sum_tree #(.NUM_PE(NPE), .NUM_ITER(NIT), .GROUP(4)) dut (
      .i_clk           (clk),
      .i_RESET_KES_n   (rst_n),
      .i_stop_dec      (stop),
      .i_EXECUTE_PE_DC (exec),
      .i_coef_2ip1     (coef),
      .o_delta_2ip1    (o_delta),
      .o_delta_valid   (o_valid),
      .o_delta_zero    (o_zero),
      .o_iter_cnt      (o_iter),
      .o_dc_done       (o_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] ref_xor(input coef_t c);
      logic [W-1:0] s;
      s = '0;
      for (int k = 0; k < NPE; k++) s = s ^ c[k*W +: W];
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per valid strobe.
   always @(negedge clk) begin
      exp_t e;
      if (o_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("delta", int'(o_delta), int'(e.d));
            chk("zero", int'(o_zero), int'(e.z));
            chk("iter_cnt", int'(o_iter), int'(e.it));
            chk("dc_done", int'(o_done), int'(e.dn));
            chk("latency", cyc, e.cyc);
         end
      end else if (o_done) begin
         chk("done_without_valid", 1, 0);
      end
   end

   // Issues n back-to-back executes; products follow each execute by one cycle.
   task automatic pulses(input coef_t cv[$]);
      exp_t e;
      int n;
      n = cv.size();
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         exec = (i < n);
         coef = (i > 0) ? cv[i-1] : '0;
         if (i < n) begin
            e.d   = ref_xor(cv[i]);
            e.z   = (e.d == '0);
            e.it  = 8'(exp_iter);
            e.dn  = (exp_iter == NIT - 1);
            e.cyc = cyc + 3;
            sb.push_back(e);
            exp_iter = (exp_iter == NIT - 1) ? 0 : exp_iter + 1;
         end
      end
      @(negedge clk);
      coef = '0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_delta"}, int'(o_delta), 0);
      chk({tag, "_zero"}, int'(o_zero), 0);
      chk({tag, "_valid"}, int'(o_valid), 0);
      chk({tag, "_iter"}, int'(o_iter), 0);
      chk({tag, "_done"}, int'(o_done), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      coef_t q[$];
      coef_t c;

      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Zero discrepancy: 14 x A5C cancel, last PE 0.
      for (int k = 0; k < NPE; k++) c[k*W +: W] = (k < NPE - 1) ? 12'hA5C : 12'h000;
      q = '{c};
      pulses(q);
      drain();

      // All-ones-LSB: odd count gives 001.
      for (int k = 0; k < NPE; k++) c[k*W +: W] = 12'h001;
      q = '{c};
      pulses(q);
      drain();

      // Stop one cycle after execute: pulse is discarded.
      @(negedge clk);
      exec = 1'b1;
      @(negedge clk);
      exec = 1'b0;
      stop = 1'b1;
      coef = {NPE{12'h123}};
      @(negedge clk);
      stop = 1'b0;
      coef = '0;
      exp_iter = 0;
      repeat (4) @(negedge clk);
      #1;
      chk("stop_delta", int'(o_delta), 0);
      chk("stop_iter", int'(o_iter), 0);

      // Full codeword plus one extra pulse to show wrap.
      q = {};
      for (int p = 0; p < NIT + 1; p++) begin
         for (int k = 0; k < NPE; k++) c[k*W +: W] = 12'($urandom);
         q.push_back(c);
      end
      pulses(q);
      drain();

      // Async reset between edges with a delta in flight.
      @(negedge clk);
      exec = 1'b1;
      @(negedge clk);
      exec = 1'b0;
      coef = {NPE{12'h777}};
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      coef = '0;
      #1 rst_n = 1'b1;
      exp_iter = 0;
      for (int k = 0; k < NPE; k++) c[k*W +: W] = 12'($urandom);
      q = '{c};
      pulses(q);
      drain();

      // Execute and stop together: no launch, counter back to 0.
      @(negedge clk);
      exec = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      exec = 1'b0;
      stop = 1'b0;
      exp_iter = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("exec_stop_iter", int'(o_iter), 0);
      for (int k = 0; k < NPE; k++) c[k*W +: W] = 12'(k * 16'h0111 + 1);
      q = '{c};
      pulses(q);
      drain();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/d_kes_dc_sum_tree.md
# d_KES_DC_sum_tree

Pipelined GF(2^12) summation stage downstream of the discrepancy-computation PE array in the KES (key equation solver) block. It takes the per-PE product terms `o_coef_2ip1` from every normal-order DC PE. It XOR-reduces them in a two-stage registered tree to form the discrepancy delta(2i+1) for the current iBM iteration, and flags it zero or non-zero. It also counts iterations and signals when the last discrepancy of a decode has been produced.

## Interface
Parameters:
- `NUM_PE`, 15: number of DC PEs feeding the tree (t+1); valid range 2..32.
- `NUM_ITER`, 14: discrepancies per codeword (t); range 1..255.
- `GROUP`, 4: stage-1 fan-in; stage 1 has ceil(NUM_PE/GROUP) partial sums.

Ports:
- `i_clk`, in, 1: clock.
- `i_RESET_KES_n`, in, 1: reset, **asynchronous, active-low**.
- `i_stop_dec`, in, 1: synchronous abort, active-high.
- `i_EXECUTE_PE_DC`, in, 1: same pulse that drives the PE array.
- `i_coef_2ip1`, in, NUM_PE*`D_KES_GF_ORDER`: concatenated PE products; PE k occupies bits [12k+11:12k].
- `o_delta_2ip1`, out, `D_KES_GF_ORDER`: registered discrepancy.
- `o_delta_valid`, out, 1: one-cycle pulse, `o_delta_2ip1` valid.
- `o_delta_zero`, out, 1: `o_delta_2ip1` == 0; qualified by `o_delta_valid`.
- `o_iter_cnt`, out, 8: index of the delta being presented (0..NUM_ITER-1).
- `o_dc_done`, out, 1: one-cycle pulse coincident with the valid of iteration NUM_ITER-1.

## Operation
- Addition is GF(2^12) addition, which is bitwise XOR. No carries; all widths stay 12 bits.
- PE products are valid the cycle after the edge at which `i_EXECUTE_PE_DC` was sampled high, because the PE captures at that edge.
- Valid pipeline, a 3-bit shift `v`:
  - `v[0]` <= `i_EXECUTE_PE_DC`.
  - `v[1]` <= `v[0]`.
  - `v[2]` <= `v[1]`, and `o_delta_valid` = `v[2]`.
- Stage 1: when `v[0]`=1, register the XOR of each GROUP-sized slice of `i_coef_2ip1` into `r_part[j]`. A short last group XORs only its existing members. When `v[0]`=0, hold.
- Stage 2: when `v[1]`=1, `o_delta_2ip1` <= XOR of all `r_part`, and `o_delta_zero` <= (that XOR == 0). Otherwise hold.
- Iteration counter: `r_iter` increments on each `o_delta_valid`.
  - At `r_iter` == NUM_ITER-1 it wraps to 0 on that valid, and `o_dc_done` pulses with it.
  - `o_iter_cnt` = `r_iter` (the index of the presented delta).
- Control states: IDLE (no `v` bit set) and BUSY (any `v` bit set). These are informational only; the datapath is fully pipelined.

## Timing
- Latency: execute sampled at edge E0, then `r_part` at E1, then `o_delta_2ip1`/`o_delta_valid` visible after E2. That is 2 cycles after the PE capture.
- Throughput: one delta per cycle. Back-to-back execute pulses yield back-to-back valids in order.
- Reset (async, low): `v`=0, `r_part`=0, `o_delta_2ip1`=0, `o_delta_zero`=0, `o_delta_valid`=0, `o_iter_cnt`=0, `o_dc_done`=0. Deassertion has no side effects; the first execute behaves normally.
- `i_stop_dec` at an edge clears `v`, `r_iter`, `r_part`, `o_delta_2ip1` and `o_delta_zero` to 0. In-flight deltas are discarded with no valid pulse.
- `i_stop_dec` and `i_EXECUTE_PE_DC` in the same cycle: stop wins; `v[0]`=0.
- Reset mid-pipeline: everything clears immediately, asynchronously.
- Extra execute pulses after `o_dc_done` start a new count from 0; no error flag.

## Structure
- `D_KES_GF_ORDER` comes from `d_KES_parameters.vh`. Add `D_KES_DC_GROUP` there as the shared default for GROUP.
- One sub-module: `d_KES_GF_xor_reduce`, a parameterised combinational N-input 12-bit XOR. Instantiate it once per stage-1 group and once for stage 2.

## Test plan
- Single pulse, NUM_PE=15, all coefficients 12'h001: 15 is odd, so `o_delta_2ip1`=12'h001 and `o_delta_zero`=0, with valid exactly 2 cycles after the capture edge.
- Coefficients alternating 12'hA5C and 12'hA5C for 14 PEs, 15th = 0: delta=0, `o_delta_zero`=1.
- Fourteen back-to-back pulses with random coefficients: 14 consecutive valids matching a reference XOR; `o_iter_cnt` 0..13; `o_dc_done` only with index 13; a following pulse shows index 0.
- `i_stop_dec` asserted 1 cycle after execute: no valid pulse, `o_delta_2ip1`=0, `o_iter_cnt`=0.
- Async reset asserted mid-pipeline, between clock edges: all outputs 0 immediately. The next execute gives a correct delta at normal latency.
- Execute and stop in the same cycle: no valid; the counter is unchanged at 0.
